// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    I_EXEC   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    JAL      = 4'd13,
    JR       = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_FUNC = 2'd2;
  localparam logic [1:0] ALU_AND  = 2'd3;

  localparam logic [1:0] ASB_B       = 2'd0;
  localparam logic [1:0] ASB_FOUR    = 2'd1;
  localparam logic [1:0] ASB_IMM     = 2'd2;
  localparam logic [1:0] ASB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG_A  = 2'd3;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

endpackage

// File: rtl/mc_perf_counters.sv
// Free-running cycle and retired-instruction counters (built only with MC_PERF_CNT_EN).
`ifdef MC_PERF_CNT_EN
module mc_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        instr_done,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      if (active) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule
`else
`endif

// File: rtl/mc_main_controller.sv
// Main control FSM for the multicycle MIPS datapath with a shared, handshaked memory.
// Optional perf counters (cycle_cnt/instr_cnt) are built when MC_PERF_CNT_EN is defined.
module mc_main_controller
  import mc_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  func,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [SELW-1:0] alu_src_b,
  output logic [SELW-1:0] alu_op,
  output logic [SELW-1:0] pc_src,
  output logic            instr_done,
  output logic            illegal_op
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  state_e state_q, state_d;
  logic   bne_q, bne_d;
  logic   unused_s;

  // The branch condition itself is resolved in the datapath.
  assign unused_s = zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bne_q   <= bne_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bne_d         = bne_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASB_B;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else begin
          state_d  = FETCH;
        end
      end
      DECODE: begin
        // ALU precomputes PC+4 + (imm<<2) for a possible branch.
        alu_src_b = ASB_IMM_SH2;
        bne_d     = (opcode == OP_BNE);
        case (opcode)
          OP_LW, OP_SW:     state_d = MEM_ADDR;
          OP_RTYPE:         state_d = (func == FN_JR) ? JR : R_EXEC;
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_J:             state_d = JUMP;
          OP_JAL:           state_d = JAL;
          OP_ADDI, OP_ANDI: state_d = I_EXEC;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d    = MEM_WR;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = RD_RD;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_src        = PC_ALUOUT;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        // PC already holds PC+4, so it is the link value written to r31.
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = RD_R31;
        mem_to_reg = M2R_PC;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JR: begin
        pc_write   = 1'b1;
        pc_src     = PC_REG_A;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  mc_perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .active     (state_q != IDLE),
    .instr_done (instr_done),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );
`else
`endif

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed self-checking bench for mc_main_controller.
module tb_mc_main_controller;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       instr_done, illegal_op;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int total;
  int bad;

  mc_main_controller dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .func          (func),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [19:0] obs_s;
  assign obs_s = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_src, instr_done, illegal_op};

  function automatic logic [19:0] ex(
    input logic pcw, input logic pcwc, input logic iord, input logic mrd,
    input logic mwr, input logic irw, input logic [1:0] rdst, input logic [1:0] m2r,
    input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
    input logic [1:0] psrc, input logic done, input logic ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step(input string tag, input logic [19:0] expected);
    #1;
    chk(tag, {12'd0, obs_s}, {12'd0, expected});
    @(negedge clk);
  endtask

  logic [19:0] e_zero, e_fetch_rdy, e_fetch_wait, e_decode, e_illegal;
  logic [19:0] e_mem_addr, e_mem_rd, e_mem_wb, e_mem_wr, e_mem_wr_done;
  logic [19:0] e_r_exec, e_r_wb, e_i_add, e_i_and, e_i_wb;
  logic [19:0] e_branch, e_jump, e_jal, e_jr;

  initial begin
    total = 0;
    bad   = 0;
    //                  pcw   pcwc  iord  mrd   mwr   irw   rdst  m2r   rw    asa   asb   aop   psrc  done  ill
    e_zero        = 20'd0;
    e_fetch_rdy   = ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    e_fetch_wait  = ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0);
    e_decode      = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0);
    e_illegal     = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b1);
    e_mem_addr    = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    e_mem_rd      = ex(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    e_mem_wb      = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    e_mem_wr      = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    e_mem_wr_done = ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    e_r_exec      = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0);
    e_r_wb        = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    e_i_add       = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0);
    e_i_and       = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 2'd3, 2'd0, 1'b0, 1'b0);
    e_i_wb        = ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
    e_branch      = ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd1, 1'b1, 1'b0);
    e_jump        = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
    e_jal         = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
    e_jr          = ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0);

    rst = 1'b1; opcode = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    step("reset_idle", e_zero);
    rst = 1'b1;
    step("idle_first_edge", e_zero);

    // lw, single-cycle memory: 5 cycles
    opcode = OP_LW;
    step("lw_fetch", e_fetch_rdy);
    step("lw_decode", e_decode);
    step("lw_mem_addr", e_mem_addr);
    step("lw_mem_rd", e_mem_rd);
    step("lw_mem_wb", e_mem_wb);

    // sw, memory stalls 3 cycles; mem_ready already low in MEM_ADDR (ignored there)
    opcode = OP_SW;
    step("sw_fetch", e_fetch_rdy);
    step("sw_decode", e_decode);
    mem_ready = 1'b0;
    step("sw_mem_addr", e_mem_addr);
    step("sw_wr_wait1", e_mem_wr);
    step("sw_wr_wait2", e_mem_wr);
    step("sw_wr_wait3", e_mem_wr);
    mem_ready = 1'b1;
    step("sw_wr_done", e_mem_wr_done);

    opcode = OP_BNE;
    step("bne_fetch", e_fetch_rdy);
    step("bne_decode", e_decode);
    step("bne_branch", e_branch);
    chk("bne_flag", {31'd0, dut.bne_q}, 32'd1);

    opcode = OP_BEQ;
    step("beq_fetch", e_fetch_rdy);
    step("beq_decode", e_decode);
    step("beq_branch", e_branch);
    chk("beq_flag", {31'd0, dut.bne_q}, 32'd0);

    opcode = OP_JAL;
    step("jal_fetch", e_fetch_rdy);
    step("jal_decode", e_decode);
    step("jal_exec", e_jal);

    opcode = OP_RTYPE; func = FN_JR;
    step("jr_fetch", e_fetch_rdy);
    step("jr_decode", e_decode);
    step("jr_exec", e_jr);

    func = 6'b100000;
    step("r_fetch", e_fetch_rdy);
    step("r_decode", e_decode);
    step("r_exec", e_r_exec);
    step("r_wb", e_r_wb);

    opcode = OP_ANDI;
    step("andi_fetch", e_fetch_rdy);
    step("andi_decode", e_decode);
    step("andi_exec", e_i_and);
    step("andi_wb", e_i_wb);

    opcode = OP_ADDI;
    step("addi_fetch", e_fetch_rdy);
    step("addi_decode", e_decode);
    step("addi_exec", e_i_add);
    step("addi_wb", e_i_wb);

    opcode = 6'b111111;
    step("ill_fetch", e_fetch_rdy);
    step("ill_decode", e_illegal);

    // lw aborted by reset while stalled in MEM_RD
    opcode = OP_LW; mem_ready = 1'b0;
    step("abort_fetch_wait", e_fetch_wait);
    mem_ready = 1'b1;
    step("abort_fetch", e_fetch_rdy);
    step("abort_decode", e_decode);
    mem_ready = 1'b0;
    step("abort_mem_addr", e_mem_addr);
    step("abort_mem_rd", e_mem_rd);
    #2 rst = 1'b0;
    #1;
    chk("abort_outputs", {12'd0, obs_s}, 32'd0);
    chk("abort_state", {28'd0, dut.state_q}, {28'd0, IDLE});
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    step("abort_idle", e_zero);

    opcode = OP_J;
    step("j_fetch", e_fetch_rdy);
    step("j_decode", e_decode);
    step("j_exec", e_jump);
`ifdef MC_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, 32'd3);
    chk("instr_cnt", instr_cnt, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
